// File: rtl/cgra_shared_mem_xbar.sv
// Shared single-port word memory with round-robin arbitration across NUM_PE ports and grant locking.
// Define CGRA_BUS_ADDR_CHECK_EN to bounds-check addresses against MEM_DEPTH and flag rsp_err.
module cgra_shared_mem_xbar #(
    parameter int unsigned NUM_PE    = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PE-1:0]           req_valid,
    input  logic [NUM_PE-1:0]           req_we,
    input  logic [NUM_PE-1:0]           req_lock,
    input  logic [NUM_PE*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PE*DATA_W-1:0]    req_wdata,
    output logic [NUM_PE-1:0]           req_ready,
    output logic [NUM_PE-1:0]           rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [$clog2(NUM_PE)-1:0]   lock_owner,
    output logic                        locked
);

    localparam int unsigned PW = $clog2(NUM_PE);
    localparam int unsigned IW = $clog2(MEM_DEPTH);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       owner_q;
    logic [NUM_PE-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   mem_q [2**IW];

    logic                grant_vld;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       cand_idx;
    logic [PW-1:0]       ptr_d;
    logic                accept;
    logic                sel_we;
    logic                sel_lock;
    logic                in_range;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [IW-1:0]       mem_idx;

    // Locked: only the owner can win. Idle: first requester at or after the pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (state_q == S_LOCKED) begin
            grant_vld = req_valid[owner_q];
            grant_idx = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_PE; k++) begin
                cand_idx = PW'((32'(ptr_q) + k) % NUM_PE);
                if (!grant_vld && req_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    assign accept = grant_vld & ~reset;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign sel_we    = req_we[grant_idx];
    assign sel_lock  = req_lock[grant_idx];
    assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];
    assign mem_idx   = IW'(sel_addr);
    assign ptr_d     = (grant_idx == PW'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;

`ifdef CGRA_BUS_ADDR_CHECK_EN
    logic rsp_err_q;
    assign in_range = (32'(sel_addr) < MEM_DEPTH);
    assign rsp_err  = rsp_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rsp_err_q <= 1'b0;
        else       rsp_err_q <= accept & ~in_range;
    end
`else
    assign in_range = 1'b1;
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= req_ready;
            rsp_rdata_q <= (accept && !sel_we && in_range) ? mem_q[mem_idx] : '0;
            if (accept) begin
                ptr_q <= ptr_d;
                case (state_q)
                    S_IDLE: if (sel_lock) begin
                        state_q <= S_LOCKED;
                        owner_q <= grant_idx;
                    end
                    S_LOCKED: if (!sel_lock) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Memory is deliberately left out of reset so its contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (accept && sel_we && in_range) mem_q[mem_idx] <= sel_wdata;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign locked     = (state_q == S_LOCKED);
    assign lock_owner = owner_q;

endmodule

// File: tb/tb_cgra_shared_mem_xbar.sv
// Self-checking bench for cgra_shared_mem_xbar: directed table, lock/reset/address sequences,
// and randomized traffic against a behavioural model of arbitration and memory.
module tb_cgra_shared_mem_xbar;

    localparam int NPE = 4;
    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int DEP = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NPE-1:0]    v_r = '0, we_r = '0, lk_r = '0;
    logic [NPE*AW-1:0] addr_r = '0;
    logic [NPE*DW-1:0] wd_r = '0;
    logic [NPE-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err, locked;
    logic [1:0]        lock_owner;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] mem_m [DEP];
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_owner = 0;
    logic [3:0]  last_ready;

    cgra_shared_mem_xbar #(.NUM_PE(NPE), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .req_valid(v_r), .req_we(we_r), .req_lock(lk_r),
        .req_addr(addr_r), .req_wdata(wd_r), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .lock_owner(lock_owner), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  v, we, lk;
        logic [10:0] a;
        logic [31:0] wd;
        logic [3:0]  rdy, rsp;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_locked = 0;
        m_owner = 0;
    endtask

    function automatic int model_grant(input logic [3:0] vv);
        if (m_locked) return vv[m_owner] ? m_owner : -1;
        for (int k = 0; k < NPE; k++) begin
            int c = (m_ptr + k) % NPE;
            if (vv[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                         input logic [10:0] a, input logic [31:0] d);
        v_r = v; we_r = we; lk_r = lk;
        for (int i = 0; i < NPE; i++) begin
            addr_r[i*AW +: AW] = a;
            wd_r[i*DW +: DW]   = d;
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic do_cycle();
        int g;
        logic [10:0] a;
        logic w, l, inr;
        logic [31:0] wdv, e_rd;
        logic [3:0] er, e_rsp;
        logic e_err;
        #1;
        g = model_grant(v_r);
        er = (g >= 0) ? 4'(1 << g) : 4'b0;
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        e_rsp = 4'b0; e_rd = 32'h0; e_err = 1'b0;
        if (g >= 0) begin
            a = addr_r[g*AW +: AW]; w = we_r[g]; l = lk_r[g]; wdv = wd_r[g*DW +: DW];
`ifdef CGRA_BUS_ADDR_CHECK_EN
            inr = (int'(a) < DEP);
`else
            inr = 1'b1;
`endif
            e_rsp = er;
            e_err = !inr;
            e_rd  = (!w && inr) ? mem_m[int'(a) % DEP] : 32'h0;
            if (w && inr) mem_m[int'(a) % DEP] = wdv;
            m_ptr = (g + 1) % NPE;
            if (m_locked) begin
                if (!l) m_locked = 0;
            end else if (l) begin
                m_locked = 1;
                m_owner = g;
            end
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("locked", 32'(locked), 32'(m_locked));
        if (m_locked) chk("lock_owner", 32'(lock_owner), 32'(m_owner));
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] pend;

        // Directed vectors, applied from ptr=0 / idle
        tbl[0]  = '{4'b0101, 4'b0101, 4'b0, 11'h020, 32'h11, 4'b0001, 4'b0001, 32'h0};
        tbl[1]  = '{4'b0100, 4'b0100, 4'b0, 11'h020, 32'h11, 4'b0100, 4'b0100, 32'h0};
        tbl[2]  = '{4'b0010, 4'b0010, 4'b0, 11'h010, 32'hDEADBEEF, 4'b0010, 4'b0010, 32'h0};
        tbl[3]  = '{4'b1000, 4'b0000, 4'b0, 11'h010, 32'h0, 4'b1000, 4'b1000, 32'hDEADBEEF};
        for (int k = 0; k < 8; k++)
            tbl[4+k] = '{4'b1111, 4'b0, 4'b0, 11'h010, 32'h0, 4'(1 << (k % 4)),
                         4'(1 << (k % 4)), 32'hDEADBEEF};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0, 11'h000, 32'h0, 4'b0000, 4'b0000, 32'h0};
        tbl[13] = '{4'b0001, 4'b0001, 4'b0, 11'h007, 32'h0, 4'b0001, 4'b0001, 32'h0};
        tbl[14] = '{4'b0001, 4'b0001, 4'b0, 11'h007, 32'h1, 4'b0001, 4'b0001, 32'h0};
        tbl[15] = '{4'b0001, 4'b0000, 4'b0, 11'h007, 32'h0, 4'b0001, 4'b0001, 32'h1};

        // Reset state, with a request pending to show req_ready is held low
        drive(4'b1111, 4'b0, 4'b0, 11'h0, 32'h0);
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_owner", 32'(lock_owner), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Preload memory so every later read has a known value
        for (int a = 0; a < DEP; a++) begin
            drive(4'b0001, 4'b0001, 4'b0, 11'(a), 32'(a * 3 + 7));
            do_cycle();
        end

        drive(4'b0, 4'b0, 4'b0, 11'h0, 32'h0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].a, tbl[i].wd);
            do_cycle();
            chk($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_rsp", i), 32'(rsp_valid), 32'(tbl[i].rsp));
            chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].rd);
        end

        // Lock: PE2 takes the lock, others are blocked, release hands over to PE3
        drive(4'b0100, 4'b0100, 4'b0, 11'd5, 32'hA5);
        do_cycle();
        drive(4'b0100, 4'b0000, 4'b0100, 11'd5, 32'h0);
        do_cycle();
        chk("lock_rdata", rsp_rdata, 32'hA5);
        chk("lock_set", 32'(locked), 32'h1);
        chk("lock_owner2", 32'(lock_owner), 32'h2);
        for (int k = 0; k < 3; k++) begin
            drive(4'b1011, 4'b0, 4'b0, 11'd5, 32'h0);
            do_cycle();
            chk("lock_block", 32'(last_ready), 32'h0);
            chk("lock_hold", 32'(locked), 32'h1);
        end
        drive(4'b1111, 4'b0100, 4'b0, 11'd5, 32'h77);
        do_cycle();
        chk("unlock_grant", 32'(last_ready), 32'b0100);
        chk("unlock", 32'(locked), 32'h0);
        drive(4'b1011, 4'b0, 4'b0, 11'd5, 32'h0);
        do_cycle();
        chk("after_unlock", 32'(last_ready), 32'b1000);
        chk("after_unlock_rd", rsp_rdata, 32'h77);

        // Async reset mid-run while locked with a response in flight
        drive(4'b0010, 4'b0, 4'b0010, 11'h010, 32'h0);
        do_cycle();
        chk("pre_rst_rsp", 32'(rsp_valid), 32'b0010);
        chk("pre_rst_owner", 32'(lock_owner), 32'h1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_err", 32'(rsp_err), 32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_owner", 32'(lock_owner), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b0101, 4'b0, 4'b0, 11'h020, 32'h0);
        do_cycle();
        chk("post_rst_grant", 32'(last_ready), 32'b0001);
        chk("post_rst_rd", rsp_rdata, 32'h11);

        // Address range handling at 1030 (beyond MEM_DEPTH)
        drive(4'b0010, 4'b0010, 4'b0, 11'd6, 32'h66);
        do_cycle();
        drive(4'b0010, 4'b0010, 4'b0, 11'd1030, 32'h55);
        do_cycle();
`ifdef CGRA_BUS_ADDR_CHECK_EN
        chk("oor_wr_err", 32'(rsp_err), 32'h1);
        drive(4'b0010, 4'b0, 4'b0, 11'd6, 32'h0);
        do_cycle();
        chk("oor_mem_kept", rsp_rdata, 32'h66);
        drive(4'b0010, 4'b0, 4'b0, 11'd1030, 32'h0);
        do_cycle();
        chk("oor_rd_data", rsp_rdata, 32'h0);
        chk("oor_rd_err", 32'(rsp_err), 32'h1);
`else
        chk("alias_wr_err", 32'(rsp_err), 32'h0);
        drive(4'b0010, 4'b0, 4'b0, 11'd6, 32'h0);
        do_cycle();
        chk("alias_rd6", rsp_rdata, 32'h55);
        drive(4'b0010, 4'b0, 4'b0, 11'd1030, 32'h0);
        do_cycle();
        chk("alias_rd1030", rsp_rdata, 32'h55);
`endif

        // Random traffic; each PE holds its request until accepted
        pend = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NPE; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i] = 1'b1;
                    we_r[i] = 1'($urandom_range(0, 1));
                    lk_r[i] = ($urandom_range(0, 3) == 0);
                    addr_r[i*AW +: AW] = 11'($urandom_range(0, 2047));
                    wd_r[i*DW +: DW] = $urandom;
                end
            end
            v_r = pend;
            do_cycle();
            pend = pend & ~last_ready;
        end

        drive(4'b0, 4'b0, 4'b0, 11'h0, 32'h0);
        do_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
